// File: rtl/depth_test_unit_if.sv
// Fragment stream, clear control, depth RAM and frame buffer signals of the
// depth test unit. The DUT uses the slave modport; the driving side uses master.
interface depth_test_unit_if #(
   parameter int FB_ADDR_WIDTH = 15,
   parameter int DEPTH_WIDTH   = 16,
   parameter int COLOR_WIDTH   = 12
);
   logic                     frag_valid;
   logic                     frag_ready;
   logic [FB_ADDR_WIDTH-1:0] frag_addr;
   logic [DEPTH_WIDTH-1:0]   frag_depth;
   logic [COLOR_WIDTH-1:0]   frag_color;
   logic                     clear_req;
   logic                     clear_busy;
   logic [FB_ADDR_WIDTH-1:0] zb_rd_addr;
   logic [DEPTH_WIDTH-1:0]   zb_rd_data;
   logic                     zb_wr_en;
   logic [FB_ADDR_WIDTH-1:0] zb_wr_addr;
   logic [DEPTH_WIDTH-1:0]   zb_wr_data;
   logic                     fb_wr_en;
   logic [FB_ADDR_WIDTH-1:0] fb_wr_addr;
   logic [COLOR_WIDTH-1:0]   fb_wr_data;
   logic [31:0]              frag_count;
   logic [31:0]              pass_count;

   modport master (
      output frag_valid, frag_addr, frag_depth, frag_color, clear_req, zb_rd_data,
      input  frag_ready, clear_busy, zb_rd_addr, zb_wr_en, zb_wr_addr, zb_wr_data,
      input  fb_wr_en, fb_wr_addr, fb_wr_data, frag_count, pass_count
   );

   modport slave (
      input  frag_valid, frag_addr, frag_depth, frag_color, clear_req, zb_rd_data,
      output frag_ready, clear_busy, zb_rd_addr, zb_wr_en, zb_wr_addr, zb_wr_data,
      output fb_wr_en, fb_wr_addr, fb_wr_data, frag_count, pass_count
   );
endinterface

// File: rtl/depth_test_unit.sv
// Z-buffer read / compare / conditional write pipeline (latency 2, one fragment
// per cycle) with write forwarding, plus a full-buffer clear sweep.
module depth_test_unit #(
   parameter int                     FB_ADDR_WIDTH = 15,
   parameter int                     FB_SIZE       = 19200,
   parameter int                     DEPTH_WIDTH   = 16,
   parameter int                     COLOR_WIDTH   = 12,
   parameter logic [DEPTH_WIDTH-1:0] CLEAR_DEPTH   = 16'h7FFF,
   parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR   = 12'h000
) (
   input logic              clk,
   input logic              rst,
   depth_test_unit_if.slave bus
);
   localparam logic [FB_ADDR_WIDTH-1:0] SWEEP_END = FB_ADDR_WIDTH'(FB_SIZE);

   typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, SWEEP = 2'd2} state_t;

   state_t                   state_q, state_d;
   logic                     drain_cnt_q, drain_cnt_d;
   logic [FB_ADDR_WIDTH-1:0] sweep_addr_q, sweep_addr_d;
   logic                     s1_valid_q, s1_valid_d;
   logic [FB_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic [DEPTH_WIDTH-1:0]   s1_depth_q, s1_depth_d;
   logic [COLOR_WIDTH-1:0]   s1_color_q, s1_color_d;
   logic                     wr_en_q, wr_en_d;
   logic [FB_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DEPTH_WIDTH-1:0]   wr_depth_q, wr_depth_d;
   logic [COLOR_WIDTH-1:0]   wr_color_q, wr_color_d;
   logic                     h1_en_q, h1_en_d;
   logic [FB_ADDR_WIDTH-1:0] h1_addr_q, h1_addr_d;
   logic [DEPTH_WIDTH-1:0]   h1_depth_q, h1_depth_d;
   logic [31:0]              frag_count_q, frag_count_d;
   logic [31:0]              pass_count_q, pass_count_d;
   logic                     accept_s;
   logic                     pass_s;
   logic [DEPTH_WIDTH-1:0]   stored_s;

   assign accept_s = bus.frag_valid && (state_q == IDLE);

   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      sweep_addr_d = sweep_addr_q;
      case (state_q)
         IDLE: begin
            if (bus.clear_req) begin
               state_d     = DRAIN;
               drain_cnt_d = 1'b0;
            end
         end
         DRAIN: begin
            if (drain_cnt_q) begin
               state_d      = SWEEP;
               sweep_addr_d = '0;
            end else begin
               drain_cnt_d = 1'b1;
            end
         end
         // SWEEP_END is reached one cycle after the last issue, so that write is still under clear_busy.
         SWEEP: begin
            if (sweep_addr_q == SWEEP_END) begin
               state_d = IDLE;
            end else begin
               sweep_addr_d = sweep_addr_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The RAM read misses the writes on zb_wr_* now and one cycle ago; take the newest matching one.
   always_comb begin
      stored_s = bus.zb_rd_data;
      if (h1_en_q && (h1_addr_q == s1_addr_q)) begin
         stored_s = h1_depth_q;
      end
      if (wr_en_q && (wr_addr_q == s1_addr_q)) begin
         stored_s = wr_depth_q;
      end
      pass_s = s1_valid_q && ($signed(s1_depth_q) < $signed(stored_s));
   end

   always_comb begin
      s1_valid_d = accept_s;
      s1_addr_d  = bus.frag_addr;
      s1_depth_d = bus.frag_depth;
      s1_color_d = bus.frag_color;
      h1_en_d    = wr_en_q;
      h1_addr_d  = wr_addr_q;
      h1_depth_d = wr_depth_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = s1_addr_q;
      wr_depth_d = s1_depth_q;
      wr_color_d = s1_color_q;
      if ((state_q == SWEEP) && (sweep_addr_q != SWEEP_END)) begin
         wr_en_d    = 1'b1;
         wr_addr_d  = sweep_addr_q;
         wr_depth_d = CLEAR_DEPTH;
         wr_color_d = CLEAR_COLOR;
      end else if (pass_s) begin
         wr_en_d = 1'b1;
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // Fragments still in flight when a clear is taken are not counted toward the new frame.
   always_comb begin
      frag_count_d = frag_count_q;
      pass_count_d = pass_count_q;
      if ((state_q == IDLE) && bus.clear_req) begin
         frag_count_d = 32'd0;
         pass_count_d = 32'd0;
      end else if (state_q == IDLE) begin
         if (accept_s) begin
            frag_count_d = frag_count_q + 32'd1;
         end
         if (pass_s) begin
            pass_count_d = pass_count_q + 32'd1;
         end
      end else begin
         frag_count_d = frag_count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         drain_cnt_q  <= 1'b0;
         sweep_addr_q <= '0;
         s1_valid_q   <= 1'b0;
         s1_addr_q    <= '0;
         s1_depth_q   <= '0;
         s1_color_q   <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_depth_q   <= '0;
         wr_color_q   <= '0;
         h1_en_q      <= 1'b0;
         h1_addr_q    <= '0;
         h1_depth_q   <= '0;
         frag_count_q <= 32'd0;
         pass_count_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         sweep_addr_q <= sweep_addr_d;
         s1_valid_q   <= s1_valid_d;
         s1_addr_q    <= s1_addr_d;
         s1_depth_q   <= s1_depth_d;
         s1_color_q   <= s1_color_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_depth_q   <= wr_depth_d;
         wr_color_q   <= wr_color_d;
         h1_en_q      <= h1_en_d;
         h1_addr_q    <= h1_addr_d;
         h1_depth_q   <= h1_depth_d;
         frag_count_q <= frag_count_d;
         pass_count_q <= pass_count_d;
      end
   end

   assign bus.frag_ready = (state_q == IDLE);
   assign bus.clear_busy = (state_q != IDLE);
   assign bus.zb_rd_addr = bus.frag_addr;
   assign bus.zb_wr_en   = wr_en_q;
   assign bus.zb_wr_addr = wr_addr_q;
   assign bus.zb_wr_data = wr_depth_q;
   assign bus.fb_wr_en   = wr_en_q;
   assign bus.fb_wr_addr = wr_addr_q;
   assign bus.fb_wr_data = wr_color_q;
   assign bus.frag_count = frag_count_q;
   assign bus.pass_count = pass_count_q;
endmodule

// File: tb/tb_depth_test_unit.sv
// Randomized and directed bench for depth_test_unit: a read-first depth RAM
// model, a write monitor, and a sequential per-fragment Z-buffer reference.
module tb_depth_test_unit;
   localparam int AW      = 15;
   localparam int DW      = 16;
   localparam int CW      = 12;
   localparam int FB_SIZE = 19200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   depth_test_unit_if #(.FB_ADDR_WIDTH(AW), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW)) bus ();

   depth_test_unit #(
      .FB_ADDR_WIDTH(AW), .FB_SIZE(FB_SIZE), .DEPTH_WIDTH(DW), .COLOR_WIDTH(CW),
      .CLEAR_DEPTH(16'h7FFF), .CLEAR_COLOR(12'h000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DW-1:0] zram [FB_SIZE];
   logic [DW-1:0] rd_data_r;
   always @(posedge clk) begin
      rd_data_r <= zram[bus.zb_rd_addr];
      if (bus.zb_wr_en) zram[bus.zb_wr_addr] <= bus.zb_wr_data;
   end
   assign bus.zb_rd_data = rd_data_r;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic          zen;
      logic          fen;
      logic          busy;
      logic [AW-1:0] zaddr;
      logic [AW-1:0] faddr;
      logic [DW-1:0] zdata;
      logic [CW-1:0] fdata;
   } wr_t;

   wr_t obs[$];
   wr_t exp_q[$];
   always @(negedge clk) begin
      if (bus.zb_wr_en || bus.fb_wr_en)
         obs.push_back('{cyc, bus.zb_wr_en, bus.fb_wr_en, bus.clear_busy,
                         bus.zb_wr_addr, bus.fb_wr_addr, bus.zb_wr_data, bus.fb_wr_data});
   end

   logic signed [DW-1:0] ref_depth [FB_SIZE];
   logic [CW-1:0]        ref_color [FB_SIZE];
   int unsigned          ref_frag = 0;
   int unsigned          ref_pass = 0;
   int                   n_pass = 0;
   int                   n_total = 0;

   // One clock of stimulus; the reference treats each accept as a complete sequential Z-test.
   task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic clr);
      logic rdy, busy;
      bus.frag_valid = v;
      bus.frag_addr  = a;
      bus.frag_depth = d;
      bus.frag_color = c;
      bus.clear_req  = clr;
      @(negedge clk);
      rdy  = bus.frag_ready;
      busy = bus.clear_busy;
      @(posedge clk);
      #1;
      if (v && rdy) begin
         ref_frag++;
         if ($signed(d) < ref_depth[a]) begin
            ref_pass++;
            ref_depth[a] = d;
            ref_color[a] = c;
            exp_q.push_back('{cyc + 1, 1'b1, 1'b1, 1'b0, a, a, d, c});
         end
      end
      if (clr && !busy) begin
         ref_frag = 0;
         ref_pass = 0;
         for (int i = 0; i < FB_SIZE; i++) begin
            ref_depth[i] = 16'h7FFF;
            ref_color[i] = 12'h000;
         end
      end
      bus.frag_valid = 1'b0;
      bus.clear_req  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.frag_valid = 1'b0;
      bus.frag_addr  = '0;
      bus.frag_depth = '0;
      bus.frag_color = '0;
      bus.clear_req  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (bus.frag_ready !== 1'b1 || bus.clear_busy !== 1'b0) begin
         $display("FAIL reset_handshake: ready=%b busy=%b expected ready=1 busy=0", bus.frag_ready, bus.clear_busy);
      end else n_pass++;
      n_total++;
      if (bus.zb_wr_en !== 1'b0 || bus.fb_wr_en !== 1'b0) begin
         $display("FAIL reset_strobes: zb=%b fb=%b expected 0 0", bus.zb_wr_en, bus.fb_wr_en);
      end else n_pass++;
      n_total++;
      if (bus.frag_count !== 32'd0 || bus.pass_count !== 32'd0) begin
         $display("FAIL reset_counts: frag=%0d pass=%0d expected 0 0", bus.frag_count, bus.pass_count);
      end else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_total++;
      if (bus.frag_ready !== 1'b1 || bus.clear_busy !== 1'b0) begin
         $display("FAIL post_reset_idle: ready=%b busy=%b expected 1 0", bus.frag_ready, bus.clear_busy);
      end else n_pass++;
   endtask

   task automatic test_clear();
      logic done;
      int   errs;
      obs.delete();
      exp_q.delete();
      step(1'b0, '0, '0, '0, 1'b1);
      n_total++;
      if (bus.clear_busy !== 1'b1 || bus.frag_ready !== 1'b0) begin
         $display("FAIL clear_start: busy=%b ready=%b expected 1 0", bus.clear_busy, bus.frag_ready);
      end else n_pass++;
      done = 1'b0;
      for (int i = 0; i < 25000 && !done; i++) begin
         step(1'b0, '0, '0, '0, 1'b0);
         if (!bus.clear_busy) done = 1'b1;
      end
      n_total++;
      if (!done) $display("FAIL clear_timeout: clear_busy still %b after 25000 cycles, expected 0", bus.clear_busy);
      else n_pass++;
      n_total++;
      if (obs.size() !== FB_SIZE) $display("FAIL sweep_count: got %0d writes expected %0d", obs.size(), FB_SIZE);
      else n_pass++;
      errs = 0;
      for (int i = 0; i < obs.size() && i < FB_SIZE; i++) begin
         if (obs[i].zaddr !== AW'(i) || obs[i].faddr !== AW'(i) || obs[i].zdata !== 16'h7FFF ||
             obs[i].fdata !== 12'h000 || obs[i].zen !== 1'b1 || obs[i].fen !== 1'b1 || obs[i].busy !== 1'b1) begin
            if (errs == 0)
               $display("FAIL sweep_write: idx %0d got addr %0d/%0d data %h/%h busy %b expected addr %0d data 7fff/000 busy 1",
                        i, obs[i].zaddr, obs[i].faddr, obs[i].zdata, obs[i].fdata, obs[i].busy, i);
            errs++;
         end
      end
      n_total++;
      if (errs != 0) $display("FAIL sweep_content: %0d bad writes expected 0", errs);
      else n_pass++;
      n_total++;
      if (bus.frag_ready !== 1'b1 || bus.frag_count !== ref_frag || bus.pass_count !== ref_pass) begin
         $display("FAIL clear_end: ready=%b frag=%0d pass=%0d expected 1 %0d %0d",
                  bus.frag_ready, bus.frag_count, bus.pass_count, ref_frag, ref_pass);
      end else n_pass++;
   endtask

   task automatic test_single();
      int c0;
      obs.delete();
      exp_q.delete();
      step(1'b1, 15'd5, 16'd100, 12'hABC, 1'b0);
      c0 = cyc;
      repeat (3) step(1'b0, '0, '0, '0, 1'b0);
      n_total++;
      if (obs.size() !== 1) $display("FAIL single_count: got %0d writes expected 1", obs.size());
      else n_pass++;
      if (obs.size() > 0) begin
         n_total++;
         if (obs[0].cyc !== c0 + 1 || obs[0].zaddr !== 15'd5 || obs[0].faddr !== 15'd5 ||
             obs[0].zdata !== 16'd100 || obs[0].fdata !== 12'hABC || obs[0].fen !== 1'b1) begin
            $display("FAIL single_write: got cyc %0d addr %0d/%0d data %0d/%h expected cyc %0d addr 5 data 100/abc",
                     obs[0].cyc, obs[0].zaddr, obs[0].faddr, obs[0].zdata, obs[0].fdata, c0 + 1);
         end else n_pass++;
      end
      n_total++;
      if (bus.pass_count !== 32'd1 || bus.frag_count !== 32'd1) begin
         $display("FAIL single_counts: frag=%0d pass=%0d expected 1 1", bus.frag_count, bus.pass_count);
      end else n_pass++;
   endtask

   task automatic test_forwarding();
      int c0;
      obs.delete();
      exp_q.delete();
      step(1'b1, 15'd7, 16'd50, 12'h111, 1'b0);
      c0 = cyc;
      step(1'b1, 15'd7, 16'd80, 12'h222, 1'b0);
      step(1'b1, 15'd7, 16'd30, 12'h333, 1'b0);
      repeat (4) step(1'b0, '0, '0, '0, 1'b0);
      n_total++;
      if (obs.size() !== 2) $display("FAIL fwd_count: got %0d writes expected 2", obs.size());
      else n_pass++;
      if (obs.size() == 2) begin
         n_total++;
         if (obs[0].zdata !== 16'd50 || obs[0].cyc !== c0 + 1 || obs[1].zdata !== 16'd30 ||
             obs[1].cyc !== c0 + 3 || obs[1].fdata !== 12'h333) begin
            $display("FAIL fwd_writes: got %0d@%0d %0d@%0d expected 50@%0d 30@%0d",
                     obs[0].zdata, obs[0].cyc, obs[1].zdata, obs[1].cyc, c0 + 1, c0 + 3);
         end else n_pass++;
      end
      n_total++;
      if (zram[7] !== 16'd30) $display("FAIL fwd_stored: got %0d expected 30", zram[7]);
      else n_pass++;
      n_total++;
      if (bus.pass_count !== 32'd3 || bus.frag_count !== 32'd4) begin
         $display("FAIL fwd_counts: frag=%0d pass=%0d expected 4 3", bus.frag_count, bus.pass_count);
      end else n_pass++;
   endtask

   task automatic test_equal_depth();
      obs.delete();
      exp_q.delete();
      step(1'b1, 15'd9, 16'd50, 12'h0F0, 1'b0);
      step(1'b1, 15'd9, 16'd50, 12'h00F, 1'b0);
      repeat (3) step(1'b0, '0, '0, '0, 1'b0);
      n_total++;
      if (obs.size() !== 1 || (obs.size() > 0 && obs[0].fdata !== 12'h0F0)) begin
         $display("FAIL equal_writes: got %0d writes expected 1 with colour 0f0", obs.size());
      end else n_pass++;
      n_total++;
      if (bus.frag_count !== 32'd6 || bus.pass_count !== 32'd4) begin
         $display("FAIL equal_counts: frag=%0d pass=%0d expected 6 4", bus.frag_count, bus.pass_count);
      end else n_pass++;
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            r;
      int            errs;
      obs.delete();
      exp_q.delete();
      for (int k = 0; k < 400; k++) begin
         r = int'($urandom_range(0, 5));
         a = (r == 0) ? AW'(FB_SIZE - 1) : AW'(20 + r);
         d = DW'(2000 - 8 * k + int'($urandom_range(0, 600)));
         step($urandom_range(0, 3) != 0, a, d, CW'($urandom), 1'b0);
      end
      repeat (4) step(1'b0, '0, '0, '0, 1'b0);
      n_total++;
      if (obs.size() !== exp_q.size()) $display("FAIL rand_count: got %0d writes expected %0d", obs.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         n_total++;
         if (obs[i].cyc !== exp_q[i].cyc || obs[i].zaddr !== exp_q[i].zaddr || obs[i].faddr !== exp_q[i].faddr ||
             obs[i].zdata !== exp_q[i].zdata || obs[i].fdata !== exp_q[i].fdata || obs[i].fen !== 1'b1) begin
            $display("FAIL rand_write: idx %0d got %0d@%0d d=%h c=%h expected %0d@%0d d=%h c=%h", i,
                     obs[i].zaddr, obs[i].cyc, obs[i].zdata, obs[i].fdata,
                     exp_q[i].zaddr, exp_q[i].cyc, exp_q[i].zdata, exp_q[i].fdata);
         end else n_pass++;
      end
      errs = 0;
      for (int i = 21; i <= 25; i++) if (zram[i] !== ref_depth[i]) errs++;
      if (zram[FB_SIZE - 1] !== ref_depth[FB_SIZE - 1]) errs++;
      n_total++;
      if (errs != 0) $display("FAIL rand_stored: %0d depth entries differ, expected 0", errs);
      else n_pass++;
      n_total++;
      if (bus.frag_count !== ref_frag || bus.pass_count !== ref_pass) begin
         $display("FAIL rand_counts: frag=%0d pass=%0d expected %0d %0d", bus.frag_count, bus.pass_count, ref_frag, ref_pass);
      end else n_pass++;
   endtask

   task automatic test_clear_with_frag();
      int   c0;
      int   errs;
      logic done;
      obs.delete();
      exp_q.delete();
      step(1'b1, 15'd3, 16'd200, 12'h5A5, 1'b1);
      c0 = cyc;
      done = 1'b0;
      for (int i = 0; i < 25000 && !done; i++) begin
         step(1'b1, 15'd11, 16'd10, 12'h111, i == 50);
         if (!bus.clear_busy) done = 1'b1;
      end
      n_total++;
      if (!done) $display("FAIL clrfrag_timeout: clear_busy still %b, expected 0", bus.clear_busy);
      else n_pass++;
      n_total++;
      if (obs.size() !== FB_SIZE + 1) $display("FAIL clrfrag_count: got %0d writes expected %0d", obs.size(), FB_SIZE + 1);
      else n_pass++;
      if (obs.size() > 0) begin
         n_total++;
         if (obs[0].cyc !== c0 + 1 || obs[0].zaddr !== 15'd3 || obs[0].zdata !== 16'd200 || obs[0].fdata !== 12'h5A5) begin
            $display("FAIL clrfrag_first: got addr %0d data %0d@%0d expected addr 3 data 200@%0d",
                     obs[0].zaddr, obs[0].zdata, obs[0].cyc, c0 + 1);
         end else n_pass++;
      end
      errs = 0;
      for (int i = 1; i < obs.size() && i <= FB_SIZE; i++)
         if (obs[i].zaddr !== AW'(i - 1) || obs[i].zdata !== 16'h7FFF || obs[i].fdata !== 12'h000) errs++;
      n_total++;
      if (errs != 0) $display("FAIL clrfrag_sweep: %0d bad sweep writes expected 0", errs);
      else n_pass++;
      n_total++;
      if (zram[3] !== 16'h7FFF) $display("FAIL clrfrag_addr3: got %h expected 7fff", zram[3]);
      else n_pass++;
      n_total++;
      if (bus.frag_count !== ref_frag || bus.pass_count !== ref_pass) begin
         $display("FAIL clrfrag_counts: frag=%0d pass=%0d expected %0d %0d", bus.frag_count, bus.pass_count, ref_frag, ref_pass);
      end else n_pass++;
   endtask

   task automatic test_reset_mid_sweep();
      logic hit;
      step(1'b0, '0, '0, '0, 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 5000 && !hit; i++) begin
         step(1'b0, '0, '0, '0, 1'b0);
         if (bus.zb_wr_en && bus.zb_wr_addr == 15'd1000) hit = 1'b1;
      end
      n_total++;
      if (!hit) $display("FAIL midrst_reach: sweep write to addr 1000 not seen, expected it");
      else n_pass++;
      rst = 1'b1;
      #1;
      obs.delete();
      n_total++;
      if (bus.zb_wr_en !== 1'b0 || bus.fb_wr_en !== 1'b0) begin
         $display("FAIL midrst_strobes: zb=%b fb=%b expected 0 0", bus.zb_wr_en, bus.fb_wr_en);
      end else n_pass++;
      n_total++;
      if (bus.clear_busy !== 1'b0 || bus.frag_ready !== 1'b1) begin
         $display("FAIL midrst_handshake: busy=%b ready=%b expected 0 1", bus.clear_busy, bus.frag_ready);
      end else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (20) step(1'b0, '0, '0, '0, 1'b0);
      n_total++;
      if (obs.size() !== 0 || bus.clear_busy !== 1'b0) begin
         $display("FAIL midrst_quiet: got %0d writes busy=%b expected 0 writes busy=0", obs.size(), bus.clear_busy);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_clear();
      test_single();
      test_forwarding();
      test_equal_depth();
      test_random();
      test_clear_with_frag();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
